// File: rtl/bus_pkg.sv
// Shared definitions for the data bus arbiter: FSM state codes, master IDs
// and the MemLen access-size codes carried through to the slaves.
package bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [2:0] {
    LEN_BYTE   = 3'd0,
    LEN_HALF   = 3'd1,
    LEN_WORD   = 3'd2,
    LEN_BYTE_U = 3'd4,
    LEN_HALF_U = 3'd5
  } mem_len_e;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// One master port of the data bus arbiter: request fields, grant,
// completion pulse and read data.
interface data_bus_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 3
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic [LEN_W-1:0] len;
  logic             gnt;
  logic             ack;
  logic [WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, len, input gnt, ack, rdata);
  modport slave  (input req, we, addr, wdata, len, output gnt, ack, rdata);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// master that did not win last time.
module rr_arb2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: default assignment first so no path leaves gnt unassigned (no latch).
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == M1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares data_mem / io between two masters, one transaction at a time.
// Optional build macro ARB_STATS_EN adds grant and conflict counters.
module data_bus_arbiter
  import bus_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DATA_SIZE = 256,
  parameter int LEN_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  data_bus_arbiter_if.slave m0,
  data_bus_arbiter_if.slave m1,
  output logic             mem_ce,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             io_wr,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic [LEN_W-1:0] bus_len,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] io_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [WIDTH-1:0] stat_gnt0,
  output logic [WIDTH-1:0] stat_gnt1,
  output logic [WIDTH-1:0] stat_conflict
`endif
);

  logic [1:0]       state;
  logic             last;
  logic             cur_id;
  logic             cur_we;
  logic [WIDTH-1:0] rdata_q;
  logic [1:0]       req;
  logic [1:0]       arb_gnt;
  logic [1:0]       gnt;
  logic             access;
  logic             is_mem;

  assign req = {m1.req, m0.req};

  rr_arb2 u_arb (
    .req  (req),
    .last (last),
    .gnt  (arb_gnt)
  );

  assign gnt    = (state == ST_IDLE) ? arb_gnt : 2'b00;
  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  // Full-width compare: high address bits must not alias into the mem region.
  assign access = (state == ST_ACCESS);
  assign is_mem = (bus_addr < WIDTH'(DATA_SIZE));
  assign mem_ce = access && is_mem;
  assign mem_rd = access && is_mem && !cur_we;
  assign mem_wr = access && is_mem && cur_we;
  assign io_wr  = access && !is_mem && cur_we;

  assign m0.ack   = (state == ST_RESP) && (cur_id == M0);
  assign m1.ack   = (state == ST_RESP) && (cur_id == M1);
  assign m0.rdata = rdata_q;
  assign m1.rdata = rdata_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= ST_IDLE;
      last      <= M1;
      cur_id    <= M0;
      cur_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_len   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            cur_id    <= gnt[1] ? M1 : M0;
            last      <= gnt[1] ? M1 : M0;
            cur_we    <= gnt[1] ? m1.we    : m0.we;
            bus_addr  <= gnt[1] ? m1.addr  : m0.addr;
            bus_wdata <= gnt[1] ? m1.wdata : m0.wdata;
            bus_len   <= gnt[1] ? m1.len   : m0.len;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Writes return zero so a stale read value never leaks into an ack.
          rdata_q <= cur_we ? '0 : (is_mem ? mem_rdata : io_rdata);
          state   <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt[0]) stat_gnt0 <= stat_gnt0 + 1'b1;
      if (gnt[1]) stat_gnt1 <= stat_gnt1 + 1'b1;
      if (state == ST_IDLE && req == 2'b11) stat_conflict <= stat_conflict + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomized scoreboard bench for data_bus_arbiter: a transaction-level
// model predicts grants, slave strobes and acks; a monitor compares each cycle.
module tb_data_bus_arbiter;
  import bus_pkg::*;

  localparam int          WIDTH     = 32;
  localparam int          DATA_SIZE = 256;
  localparam int          LEN_W     = 3;
  localparam logic [31:0] IO_KEY    = 32'h5A5A_C3C3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_bus_arbiter_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) m0_if ();
  data_bus_arbiter_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) m1_if ();

  logic             mem_ce, mem_rd, mem_wr, io_wr;
  logic [WIDTH-1:0] bus_addr, bus_wdata, mem_rdata, io_rdata;
  logic [LEN_W-1:0] bus_len;
`ifdef ARB_STATS_EN
  logic [WIDTH-1:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  data_bus_arbiter #(.WIDTH(WIDTH), .DATA_SIZE(DATA_SIZE), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .m0            (m0_if),
    .m1            (m1_if),
    .mem_ce        (mem_ce),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .io_wr         (io_wr),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_len       (bus_len),
    .mem_rdata     (mem_rdata),
    .io_rdata      (io_rdata)
`ifdef ARB_STATS_EN
    ,
    .stat_gnt0     (stat_gnt0),
    .stat_gnt1     (stat_gnt1),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Slave models: word-per-address data_mem, io returns a keyed address.
  logic [31:0] mem_arr [DATA_SIZE];
  assign mem_rdata = (bus_addr < DATA_SIZE) ? mem_arr[bus_addr[7:0]] : 32'hBAD0_BAD0;
  assign io_rdata  = bus_addr ^ IO_KEY;
  always @(posedge clk)
    if (mem_ce && mem_wr && bus_addr < DATA_SIZE) mem_arr[bus_addr[7:0]] <= bus_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int          due;
    bit          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  len;
    logic [31:0] rdata;
  } txn_t;

  logic [31:0] shadow [DATA_SIZE];
  txn_t        acc_q[$];
  txn_t        sb_q[$];
  int          gnt_log[$];
  bit          last_m = 1'b1;
  int          busy_until = 0;
  int          cyc = 0;
  int          model_g0 = 0, model_g1 = 0, model_conf = 0;

  function automatic logic [31:0] expect_read(input logic [31:0] addr);
    return (addr < DATA_SIZE) ? shadow[addr[7:0]] : (addr ^ IO_KEY);
  endfunction

  initial begin : monitor
    txn_t        t;
    txn_t        r_t;
    bit          have_ack;
    bit          is_mem;
    bit          winner;
    logic [3:0]  exp_s;
    logic [1:0]  exp_a, exp_g, r;
    forever begin
      @(negedge clk);
      exp_s = 4'b0000;
      if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
        t = acc_q.pop_front();
        is_mem = (t.addr < DATA_SIZE);
        exp_s = {is_mem, is_mem & ~t.we, is_mem & t.we, ~is_mem & t.we};
        check("bus_addr", bus_addr, t.addr);
        check("bus_wdata", bus_wdata, t.wdata);
        check("bus_len", bus_len, t.len);
      end
      check("strobes", {mem_ce, mem_rd, mem_wr, io_wr}, exp_s);

      exp_a = 2'b00;
      have_ack = 1'b0;
      if (sb_q.size() > 0 && (sb_q[0].due == cyc || m0_if.ack || m1_if.ack)) begin
        r_t = sb_q.pop_front();
        have_ack = 1'b1;
        exp_a = (r_t.due == cyc) ? (r_t.id ? 2'b10 : 2'b01) : 2'b00;
      end
      check("ack", {m1_if.ack, m0_if.ack}, exp_a);
      if (have_ack)
        check(r_t.id ? "rdata1" : "rdata0", r_t.id ? m1_if.rdata : m0_if.rdata, r_t.rdata);

      if (rst) begin
        acc_q.delete();
        sb_q.delete();
        last_m     = 1'b1;
        busy_until = cyc + 1;
        model_g0   = 0;
        model_g1   = 0;
        model_conf = 0;
      end else begin
        r     = {m1_if.req, m0_if.req};
        exp_g = 2'b00;
        if (cyc >= busy_until && r != 2'b00) begin
          winner = (r == 2'b11) ? ~last_m : r[1];
          exp_g  = winner ? 2'b10 : 2'b01;
          if (r == 2'b11) model_conf++;
        end
        check("gnt", {m1_if.gnt, m0_if.gnt}, exp_g);
        if (exp_g != 2'b00) begin
          t.id    = winner;
          t.we    = winner ? m1_if.we    : m0_if.we;
          t.addr  = winner ? m1_if.addr  : m0_if.addr;
          t.wdata = winner ? m1_if.wdata : m0_if.wdata;
          t.len   = winner ? m1_if.len   : m0_if.len;
          t.rdata = t.we ? 32'h0 : expect_read(t.addr);
          if (t.we && t.addr < DATA_SIZE) shadow[t.addr[7:0]] = t.wdata;
          t.due = cyc + 1;
          acc_q.push_back(t);
          t.due = cyc + 2;
          sb_q.push_back(t);
          last_m     = winner;
          busy_until = cyc + 3;
          gnt_log.push_back(int'(winner));
          if (winner) model_g1++; else model_g0++;
        end
      end
      cyc++;
    end
  end

  // Called at posedge+1; holds the request until granted, then releases it.
  task automatic drive(input bit m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] len);
    int   waited = 0;
    logic seen   = 1'b0;
    if (m) begin
      m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.len = len; m1_if.req = 1'b1;
    end else begin
      m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.len = len; m0_if.req = 1'b1;
    end
    while (!seen && waited < 100) begin
      @(negedge clk);
      waited++;
      seen = m ? m1_if.gnt : m0_if.gnt;
    end
    check("gnt_wait", seen, 1'b1);
    @(posedge clk);
    #1;
    if (m) m1_if.req = 1'b0; else m0_if.req = 1'b0;
  endtask

  // A request raised and withdrawn inside a busy window must leave no trace.
  task automatic pulse(input bit m);
    if (m) begin
      m1_if.we = 1'b1; m1_if.addr = 32'h44; m1_if.wdata = $urandom; m1_if.req = 1'b1;
    end else begin
      m0_if.we = 1'b1; m0_if.addr = 32'h48; m0_if.wdata = $urandom; m0_if.req = 1'b1;
    end
    @(posedge clk);
    #1;
    if (m) m1_if.req = 1'b0; else m0_if.req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0, 1, 2: return {24'h0, 4'($urandom_range(0, 7)), 4'h0};
      3:       return 32'h0000_00FF;
      4:       return 32'h0000_0100;
      5:       return 32'h8000_0010;
      6:       return $urandom;
      default: return 32'h0000_0010;
    endcase
  endfunction

  task automatic rand_master(input bit m, input int n);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 4) == 0 && cyc < busy_until) pulse(m);
      drive(m, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 3'($urandom_range(0, 5)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          base;
    int          got_id;
    logic [31:0] exp_order [4];
    exp_order = '{32'd0, 32'd1, 32'd0, 32'd1};
    for (int i = 0; i < DATA_SIZE; i++) begin
      mem_arr[i] = 32'h0;
      shadow[i]  = 32'h0;
    end
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.len = '0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.len = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_gnt", {m1_if.gnt, m0_if.gnt}, 2'b00);
    check("rst_ack", {m1_if.ack, m0_if.ack}, 2'b00);
    check("rst_strobes", {mem_ce, mem_rd, mem_wr, io_wr}, 4'b0000);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_rdata", m0_if.rdata, 32'h0);
    @(posedge clk);
    #1;

    // Both masters contend continuously: expect M0, M1, M0, M1.
    base = gnt_log.size();
    fork
      begin
        drive(0, 1'b1, 32'h40, 32'h1111_0000, LEN_WORD);
        drive(0, 1'b1, 32'h50, 32'h2222_0000, LEN_HALF);
        drive(0, 1'b0, 32'h40, 32'h0, LEN_BYTE);
      end
      begin
        drive(1, 1'b0, 32'h40, 32'h0, LEN_WORD);
        drive(1, 1'b0, 32'h50, 32'h0, LEN_HALF_U);
      end
    join
    for (int i = 0; i < 4; i++) begin
      got_id = (base + i < gnt_log.size()) ? gnt_log[base + i] : 9;
      check("tie_order", 64'(got_id), 64'(exp_order[i]));
    end
`ifdef ARB_STATS_EN
    @(negedge clk);
    check("stat_conflict_tie", stat_conflict, 32'd4);
    check("stat_gnt0_tie", stat_gnt0, 32'd3);
    check("stat_gnt1_tie", stat_gnt1, 32'd2);
    @(posedge clk);
    #1;
`endif

    drive(0, 1'b1, 32'h10, 32'hDEAD_BEEF, LEN_WORD);
    drive(1, 1'b0, 32'h10, 32'h0, LEN_WORD);
    drive(0, 1'b1, 32'hFF, 32'hCAFE_F00D, LEN_WORD);
    drive(0, 1'b1, 32'h100, 32'h5, LEN_WORD);
    drive(1, 1'b0, 32'hFF, 32'h0, LEN_WORD);
    drive(1, 1'b0, 32'h100, 32'h0, LEN_BYTE_U);

    // Reset while the write is in its ACCESS cycle.
    drive(0, 1'b1, 32'h20, 32'h0000_1234, LEN_WORD);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_strobes", {mem_ce, mem_rd, mem_wr, io_wr}, 4'b0000);
    check("midrst_ack", {m1_if.ack, m0_if.ack}, 2'b00);
    check("midrst_bus_addr", bus_addr, 32'h0);
    @(posedge clk);
    #1;
    base = gnt_log.size();
    fork
      drive(1, 1'b0, 32'h20, 32'h0, LEN_WORD);
      drive(0, 1'b0, 32'h100, 32'h0, LEN_WORD);
    join
    got_id = (base < gnt_log.size()) ? gnt_log[base] : 9;
    check("post_rst_tie", 64'(got_id), 64'(0));

    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join

    repeat (6) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'(0));
`ifdef ARB_STATS_EN
    check("stat_gnt0", stat_gnt0, 32'(model_g0));
    check("stat_gnt1", stat_gnt1, 32'(model_g1));
    check("stat_conflict", stat_conflict, 32'(model_conf));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
